// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC datapath types and default widths
// Contents: reader FSM state enum, default operand/length/buffer widths,
// stall counter width.
package mac_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_LEN_WIDTH   = 8;
  localparam int unsigned DEFAULT_BUFFER_SIZE = 4;
  localparam int unsigned STALL_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } reader_state_e;

endpackage

// File: rtl/fifo_operand_reader_if.sv
// rtl/fifo_operand_reader_if.sv - FIFO dual-pop lanes plus operand output handshake
// Signals: Empty/ReadyM/DataOut1/DataOut2 (FIFO lane status and head words),
// Pop1/Pop2 (lane pops), OutValid/OutReady/OutP/OutM (operand pair stream).
// master: the reader side; slave: the FIFO plus MAC side.
interface fifo_operand_reader_if
  import mac_pkg::*;
#(
  parameter int unsigned DataWidth  = DEFAULT_DATA_WIDTH,
  parameter int unsigned BufferSize = DEFAULT_BUFFER_SIZE
);

  logic                  Empty;
  logic [BufferSize-1:0] ReadyM;
  logic [DataWidth-1:0]  DataOut1;
  logic [DataWidth-1:0]  DataOut2;
  logic                  Pop1;
  logic                  Pop2;
  logic                  OutValid;
  logic                  OutReady;
  logic [DataWidth-1:0]  OutP;
  logic [DataWidth-1:0]  OutM;

  modport master (
    input  Empty, ReadyM, DataOut1, DataOut2, OutReady,
    output Pop1, Pop2, OutValid, OutP, OutM
  );

  modport slave (
    output Empty, ReadyM, DataOut1, DataOut2, OutReady,
    input  Pop1, Pop2, OutValid, OutP, OutM
  );

endinterface

// File: rtl/reader_stall_counter.sv
// rtl/reader_stall_counter.sv - saturating stall cycle counter with clear
// Ports: clk, aclr (async active-low), clr (synchronous clear, wins over inc),
// inc (count one cycle), cnt (current count, holds at all-ones).
module reader_stall_counter
  import mac_pkg::*;
(
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       clr,
  input  logic                       inc,
  output logic [STALL_CNT_WIDTH-1:0] cnt
);

  logic [STALL_CNT_WIDTH-1:0] cnt_q;
  logic [STALL_CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fifo_operand_reader.sv
// rtl/fifo_operand_reader.sv - lock-step dual-lane FIFO reader with registered operand stage
// Ports: clk, aclr (async active-low), Start/Len (job start pulse and pair count),
// bus (fifo_operand_reader_if.master: lane status, pops, operand stream),
// Busy (job in RUN or DONE), Done (one-cycle job completion pulse),
// StallCnt (lane-starved cycle count).
// Build option: FIFO_READER_STALL_CNT_EN enables the stall counter; otherwise
// StallCnt is constant zero.
module fifo_operand_reader
  import mac_pkg::*;
#(
  parameter int unsigned DataWidth  = DEFAULT_DATA_WIDTH,
  parameter int unsigned BufferSize = DEFAULT_BUFFER_SIZE,
  parameter int unsigned LenWidth   = DEFAULT_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       Start,
  input  logic [LenWidth-1:0]        Len,
  fifo_operand_reader_if.master      bus,
  output logic                       Busy,
  output logic                       Done,
  output logic [STALL_CNT_WIDTH-1:0] StallCnt
);

  reader_state_e         state_q, state_d;
  logic [LenWidth-1:0]   remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DataWidth-1:0]  out_p_q, out_p_d;
  logic [DataWidth-1:0]  out_m_q, out_m_d;

  logic [BufferSize-1:0] ready_m;
  logic                  avail_p;
  logic                  avail_m;
  logic                  stage_free;
  logic                  load;

  assign ready_m    = bus.ReadyM;
  assign avail_p    = ~bus.Empty;
  assign avail_m    = |ready_m;
  // The stage can take a new pair if it is empty or its pair leaves this cycle.
  assign stage_free = ~out_valid_q | bus.OutReady;
  // Both lanes must be readable; a single-lane pop would desynchronise P and M.
  assign load       = (state_q == RUN) && (remaining_q != '0) &&
                      avail_p && avail_m && stage_free;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_m_d     = out_m_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            state_d     = RUN;
            remaining_d = Len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (load) begin
          out_p_d     = bus.DataOut1;
          out_m_d     = bus.DataOut2;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - 1'b1;
        end else if (out_valid_q && bus.OutReady) begin
          out_valid_d = 1'b0;
        end
        // All pairs popped and the last one drained (or draining now).
        if ((remaining_q == '0) && stage_free) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_m_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_m_q     <= out_m_d;
    end
  end

  assign bus.Pop1     = load;
  assign bus.Pop2     = load;
  assign bus.OutValid = out_valid_q;
  assign bus.OutP     = out_p_q;
  assign bus.OutM     = out_m_q;
  assign Busy         = (state_q == RUN) || (state_q == DONE);
  assign Done         = (state_q == DONE);

`ifdef FIFO_READER_STALL_CNT_EN
  logic stall_inc;
  logic stall_clr;

  // Only starvation counts: a full stage waiting on the MAC is not a stall.
  assign stall_inc = (state_q == RUN) && (remaining_q != '0) && stage_free &&
                     !(avail_p && avail_m);
  assign stall_clr = (state_q == IDLE) && Start;

  reader_stall_counter u_stall_counter (
    .clk  (clk),
    .aclr (aclr),
    .clr  (stall_clr),
    .inc  (stall_inc),
    .cnt  (StallCnt)
  );
`else
  assign StallCnt = '0;
`endif

endmodule

// File: doc/fifo_operand_reader.md
# fifo_operand_reader

Consumer-side controller for the dual-read-pointer operand FIFO in the MAC datapath. The FIFO has one push and two independent pops (P lane, M lane). This block watches both lanes' availability, pops them in lock-step, and captures each pair into a registered output stage. The MAC engine drains that stage through a valid/ready handshake. A job is a programmed number of operand pairs, started by a pulse and closed by a done pulse.

## Interface
- DataWidth, 32, width of one FIFO word and of each output operand
- BufferSize, 4, FIFO depth; width of the ReadyM mask
- LenWidth, 8, width of the job length field and the remaining counter
- clk  input  1  rising-edge clock
- aclr  input  1  asynchronous, active-low reset; one clock domain only
- Start  input  1  one-cycle job start pulse; sampled only in IDLE
- Len  input  LenWidth  number of operand pairs in the job; sampled with Start
- Empty  input  1  FIFO P lane has no readable entry
- ReadyM  input  BufferSize  FIFO per-slot readable mask for the M lane
- DataOut1  input  DataWidth  FIFO P-lane head word (combinational read)
- DataOut2  input  DataWidth  FIFO M-lane head word (combinational read)
- Pop1  output  1  advance FIFO P-lane read pointer
- Pop2  output  1  advance FIFO M-lane read pointer
- OutValid  output  1  OutP/OutM hold a valid pair
- OutReady  input  1  MAC accepts the pair this cycle
- OutP  output  DataWidth  registered P operand
- OutM  output  DataWidth  registered M operand
- Busy  output  1  job in progress (RUN or DONE state)
- Done  output  1  one-cycle pulse when the job's last pair is accepted
- StallCnt  output  16  count of FIFO-starved cycles (see Configuration)

## Operation
- Lane availability: AvailP = ~Empty; AvailM = |ReadyM.
- States:
  - IDLE: Start with Len != 0 -> RUN, Remaining <= Len. Start with Len == 0 -> DONE directly, with no pops.
  - RUN: leave for DONE when Remaining == 0 and the output stage is empty or being accepted this cycle.
  - DONE: Done = 1 for exactly one cycle, then -> IDLE.
- Load = RUN & (Remaining != 0) & AvailP & AvailM & (~OutValid | OutReady).
- Pop1 = Pop2 = Load. The two pops are always asserted together, never singly.
- On Load:
  - OutP <= DataOut1; OutM <= DataOut2.
  - OutValid <= 1.
  - Remaining <= Remaining - 1 (never wraps below 0).
- On OutValid & OutReady & ~Load: OutValid <= 0. OutP/OutM hold their last value.
- Simultaneous accept and load: the new pair replaces the old one; OutValid stays 1.
- Start while Busy is ignored. Len is not re-sampled mid-job.
- One lane available and the other not: no pop. Starvation on either lane stalls both.
- Reset values: Pop1/Pop2 = 0 and OutValid = 0 while aclr is low, independent of clk.
  - OutP/OutM = 0; Busy = 0; Done = 0; StallCnt = 0; state = IDLE; Remaining = 0.
- Reset mid-job: everything returns to reset values immediately. Popped-but-unaccepted data is discarded; the FIFO is reset alongside on the same aclr.

## Timing
- Start seen at edge t -> RUN at t+1. The earliest Pop is during cycle t+1; OutValid is first high in cycle t+2.
- Pop-to-OutValid latency: 1 cycle.
- Throughput: 1 pair/cycle while both lanes stay available and OutReady is held high.
- OutP/OutM/OutValid must hold stable while OutValid & ~OutReady.
- Last pair accepted at edge t -> Done high during cycle t+1 -> IDLE at t+2, where a new Start is accepted.
- Len == 0: Start at edge t -> Done during cycle t+1.

## Configuration
- FIFO_READER_STALL_CNT_EN defined:
  - StallCnt increments by 1 (saturating at 16'hFFFF) each cycle in RUN where Remaining != 0, the output stage is free, and Load = 0 because of lane unavailability.
  - StallCnt clears on accepted Start.
- Not defined: StallCnt is tied to 0 and no counter logic is synthesized. The port is always present.

## Structure
- Shared package mac_pkg: the state enum typedef (IDLE, RUN, DONE) and the default DataWidth/LenWidth constants.
- One sub-module, reader_stall_counter: 16-bit saturating counter with clear and increment. It is instantiated only under FIFO_READER_STALL_CNT_EN.
- The output register stage and the FSM stay in the top module.

## Test plan
- Reset held low mid-RUN with OutValid = 1 -> OutValid, Pop1/Pop2, Busy drop to 0 asynchronously; state returns to IDLE; StallCnt = 0.
- Len = 4, FIFO pre-filled with 4 pairs (P = 1..4, M = 10..40), OutReady = 1 -> pops on 4 consecutive cycles. Outputs are (1,10),(2,20),(3,30),(4,40) on consecutive cycles. Done is pulsed once, one cycle after the last accept.
- Len = 3, OutReady low for 5 cycles after the first pair -> (1,10) held stable and no further pops. On OutReady rise, the remaining pairs follow back-to-back.
- P lane has 3 entries, M lane has 1, Len = 3 -> exactly one pop pair; Pop1 never asserted without Pop2. With the macro, StallCnt counts each starved cycle until M is refilled.
- Start with Len = 0 -> no pops; Done high in cycle t+1. A second Start during Busy is ignored and Remaining is unchanged.
